// File: rtl/hash_sched_pkg.sv
// Shared types for the cuckoo insert scheduler: pipeline opcodes, FSM states, stats width.
package hash_sched_pkg;

  localparam int unsigned STATS_WIDTH = 16;

  typedef enum logic [1:0] {
    OpLookup = 2'd0,
    OpInsert = 2'd1,
    OpDelete = 2'd2,
    OpRsvd   = 2'd3
  } hash_op_e;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StChain    = 2'd1,
    StReinject = 2'd2
  } sched_state_e;

endpackage

// File: rtl/evict_holding_reg.sv
// One-entry holding buffer for an element displaced from the last table.
module evict_holding_reg #(
  parameter int unsigned KEY_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o
);

  logic [KEY_WIDTH-1:0]  key_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  full_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q  <= '0;
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      key_q  <= key_i;
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end
  end

  assign key_o  = key_q;
  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/hash_insert_scheduler.sv
// Issue scheduler for the multi-table cuckoo pipeline: one insert kick-chain at a time.
// Optional saturating kick/fail counters are built when HASH_SCHED_STATS_EN is defined.
module hash_insert_scheduler
  import hash_sched_pkg::*;
#(
  parameter int unsigned KEY_WIDTH    = 2,
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned PIPE_LATENCY = 4,
  parameter int unsigned MAX_KICKS    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [KEY_WIDTH-1:0]   req_key_i,
  input  logic [DATA_WIDTH-1:0]  req_data_i,
  input  logic                   evict_valid_i,
  input  logic [KEY_WIDTH-1:0]   evict_key_i,
  input  logic [DATA_WIDTH-1:0]  evict_data_i,
  input  logic                   op_retire_i,
  input  logic                   op_retire_is_insert_i,
  output logic                   pipe_clk_en_o,
  output logic                   pipe_valid_o,
  output logic [1:0]             pipe_op_o,
  output logic [KEY_WIDTH-1:0]   pipe_key_o,
  output logic [DATA_WIDTH-1:0]  pipe_data_o,
  output logic                   ins_done_o,
  output logic                   ins_fail_o,
  output logic [KEY_WIDTH-1:0]   fail_key_o,
  output logic [DATA_WIDTH-1:0]  fail_data_o,
  output logic                   idle_o,
  output logic                   err_o,
  output logic [STATS_WIDTH-1:0] kick_total_o,
  output logic [STATS_WIDTH-1:0] fail_total_o
);

  localparam int unsigned InflightW = $clog2(PIPE_LATENCY + 1);
  localparam int unsigned KickW     = $clog2(MAX_KICKS + 1);
  localparam logic [KickW-1:0]     KickMax     = KickW'(MAX_KICKS);
  localparam logic [InflightW-1:0] InflightMax = '1;

  sched_state_e state_q, state_d;
  logic [KickW-1:0]     kick_cnt_q, kick_cnt_d;
  logic [InflightW-1:0] inflight_q, inflight_d;
  logic                 err_q, err_d;
  logic                 pipe_valid_q, pipe_valid_d;
  logic [1:0]           pipe_op_q, pipe_op_d;
  logic [KEY_WIDTH-1:0] pipe_key_q, pipe_key_d;
  logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
  logic                 ins_done_q, ins_done_d;
  logic                 ins_fail_q, ins_fail_d;
  logic [KEY_WIDTH-1:0] fail_key_q, fail_key_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

  hash_op_e              req_op;
  logic                  buf_full;
  logic [KEY_WIDTH-1:0]  buf_key;
  logic [DATA_WIDTH-1:0] buf_data;
  logic req_ready, req_accept, issue_evict, issue_req, pipe_issue;
  logic chain_evict, chain_fail, chain_done, buf_load, underflow;

  assign req_op = hash_op_e'(req_op_i);

  // Only one chain may exist, so a new INSERT waits until the FSM is back in IDLE.
  assign req_ready   = !stall_i && !buf_full && !evict_valid_i &&
                       !(req_op == OpInsert && state_q != StIdle);
  assign req_accept  = req_valid_i && req_ready;
  assign issue_evict = (state_q == StReinject) && buf_full && !stall_i;
  assign issue_req   = req_accept && (req_op != OpRsvd);
  assign pipe_issue  = issue_evict || issue_req;

  assign chain_evict = (state_q == StChain) && evict_valid_i;
  assign chain_fail  = chain_evict && (kick_cnt_q == KickMax);
  assign buf_load    = chain_evict && (kick_cnt_q != KickMax);
  assign chain_done  = (state_q == StChain) && !evict_valid_i &&
                       op_retire_i && op_retire_is_insert_i;
  assign underflow   = op_retire_i && !pipe_issue && (inflight_q == '0);

  evict_holding_reg #(
    .KEY_WIDTH  (KEY_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_evict_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .clear_i (issue_evict),
    .key_i   (evict_key_i),
    .data_i  (evict_data_i),
    .key_o   (buf_key),
    .data_o  (buf_data),
    .full_o  (buf_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (req_accept && req_op == OpInsert) state_d = StChain;
      StChain: begin
        if (chain_fail || chain_done) state_d = StIdle;
        else if (buf_load)            state_d = StReinject;
      end
      StReinject: if (issue_evict) state_d = StChain;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    pipe_valid_d = pipe_issue;
    pipe_op_d    = '0;
    pipe_key_d   = '0;
    pipe_data_d  = '0;
    if (issue_evict) begin
      pipe_op_d   = OpInsert;
      pipe_key_d  = buf_key;
      pipe_data_d = buf_data;
    end else if (issue_req) begin
      pipe_op_d   = req_op_i;
      pipe_key_d  = req_key_i;
      pipe_data_d = req_data_i;
    end

    ins_done_d  = chain_done;
    ins_fail_d  = chain_fail;
    fail_key_d  = chain_fail ? evict_key_i : '0;
    fail_data_d = chain_fail ? evict_data_i : '0;

    kick_cnt_d = kick_cnt_q;
    if (chain_fail || chain_done) kick_cnt_d = '0;
    else if (buf_load)            kick_cnt_d = kick_cnt_q + 1'b1;

    inflight_d = inflight_q;
    unique case ({pipe_issue, op_retire_i})
      2'b10:   if (inflight_q != InflightMax) inflight_d = inflight_q + 1'b1;
      2'b01:   if (!underflow) inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    err_d = err_q || (req_accept && req_op == OpRsvd) ||
            (state_q == StIdle && evict_valid_i) || underflow;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kick_cnt_q   <= '0;
      inflight_q   <= '0;
      err_q        <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_op_q    <= '0;
      pipe_key_q   <= '0;
      pipe_data_q  <= '0;
      ins_done_q   <= 1'b0;
      ins_fail_q   <= 1'b0;
      fail_key_q   <= '0;
      fail_data_q  <= '0;
    end else begin
      kick_cnt_q   <= kick_cnt_d;
      inflight_q   <= inflight_d;
      err_q        <= err_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_op_q    <= pipe_op_d;
      pipe_key_q   <= pipe_key_d;
      pipe_data_q  <= pipe_data_d;
      ins_done_q   <= ins_done_d;
      ins_fail_q   <= ins_fail_d;
      fail_key_q   <= fail_key_d;
      fail_data_q  <= fail_data_d;
    end
  end

`ifdef HASH_SCHED_STATS_EN
  logic [STATS_WIDTH-1:0] kick_total_q, fail_total_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kick_total_q <= '0;
      fail_total_q <= '0;
    end else begin
      if (buf_load && kick_total_q != '1)   kick_total_q <= kick_total_q + 1'b1;
      if (chain_fail && fail_total_q != '1) fail_total_q <= fail_total_q + 1'b1;
    end
  end

  assign kick_total_o = kick_total_q;
  assign fail_total_o = fail_total_q;
`else
  assign kick_total_o = '0;
  assign fail_total_o = '0;
`endif

  assign req_ready_o   = req_ready;
  assign pipe_clk_en_o = !stall_i;
  assign pipe_valid_o  = pipe_valid_q;
  assign pipe_op_o     = pipe_op_q;
  assign pipe_key_o    = pipe_key_q;
  assign pipe_data_o   = pipe_data_q;
  assign ins_done_o    = ins_done_q;
  assign ins_fail_o    = ins_fail_q;
  assign fail_key_o    = fail_key_q;
  assign fail_data_o   = fail_data_q;
  assign idle_o        = (state_q == StIdle) && !buf_full && (inflight_q == '0);
  assign err_o         = err_q;

endmodule

// File: tb/tb_hash_insert_scheduler.sv
// Bench for hash_insert_scheduler: directed scenarios plus random traffic against a chain model.
module tb_hash_insert_scheduler;

  localparam int KW = 2;
  localparam int DW = 4;
  localparam int PL = 4;
  localparam int MK = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall_i = 1'b0, req_valid_i = 1'b0, evict_valid_i = 1'b0;
  logic op_retire_i = 1'b0, op_retire_is_insert_i = 1'b0;
  logic [1:0] req_op_i = '0;
  logic [KW-1:0] req_key_i = '0, evict_key_i = '0;
  logic [DW-1:0] req_data_i = '0, evict_data_i = '0;
  logic req_ready_o, pipe_clk_en_o, pipe_valid_o, ins_done_o, ins_fail_o, idle_o, err_o;
  logic [1:0] pipe_op_o;
  logic [KW-1:0] pipe_key_o, fail_key_o;
  logic [DW-1:0] pipe_data_o, fail_data_o;
  logic [15:0] kick_total_o, fail_total_o;

  always #5 clk = ~clk;

  hash_insert_scheduler #(
    .KEY_WIDTH    (KW),
    .DATA_WIDTH   (DW),
    .PIPE_LATENCY (PL),
    .MAX_KICKS    (MK)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .stall_i               (stall_i),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_op_i              (req_op_i),
    .req_key_i             (req_key_i),
    .req_data_i            (req_data_i),
    .evict_valid_i         (evict_valid_i),
    .evict_key_i           (evict_key_i),
    .evict_data_i          (evict_data_i),
    .op_retire_i           (op_retire_i),
    .op_retire_is_insert_i (op_retire_is_insert_i),
    .pipe_clk_en_o         (pipe_clk_en_o),
    .pipe_valid_o          (pipe_valid_o),
    .pipe_op_o             (pipe_op_o),
    .pipe_key_o            (pipe_key_o),
    .pipe_data_o           (pipe_data_o),
    .ins_done_o            (ins_done_o),
    .ins_fail_o            (ins_fail_o),
    .fail_key_o            (fail_key_o),
    .fail_data_o           (fail_data_o),
    .idle_o                (idle_o),
    .err_o                 (err_o),
    .kick_total_o          (kick_total_o),
    .fail_total_o          (fail_total_o)
  );

  int checks = 0;
  int errors = 0;

  // Chain model: is a chain open, the pending displaced element, kicks used, ops in flight.
  bit m_chain;
  int m_kicks;
  int m_infl;
  bit m_err;
  int m_ktot;
  int m_ftot;
  int m_pend_key[$];
  int m_pend_data[$];

  bit e_pv, e_done, e_fail;
  int e_op, e_key, e_data, e_fk, e_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_chain = 0; m_kicks = 0; m_infl = 0; m_err = 0; m_ktot = 0; m_ftot = 0;
    m_pend_key.delete(); m_pend_data.delete();
    e_pv = 0; e_done = 0; e_fail = 0; e_op = 0; e_key = 0; e_data = 0; e_fk = 0; e_fd = 0;
  endtask

  function automatic int exp_ktot();
`ifdef HASH_SCHED_STATS_EN
    return m_ktot;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_ftot();
`ifdef HASH_SCHED_STATS_EN
    return m_ftot;
`else
    return 0;
`endif
  endfunction

  task automatic check_regs();
    chk("pipe_valid", pipe_valid_o, e_pv);
    chk("pipe_op", pipe_op_o, e_op);
    chk("pipe_key", pipe_key_o, e_key);
    chk("pipe_data", pipe_data_o, e_data);
    chk("ins_done", ins_done_o, e_done);
    chk("ins_fail", ins_fail_o, e_fail);
    chk("fail_key", fail_key_o, e_fk);
    chk("fail_data", fail_data_o, e_fd);
    chk("err", err_o, m_err);
    chk("idle", idle_o, (!m_chain && m_pend_key.size() == 0 && m_infl == 0));
    chk("kick_total", kick_total_o, exp_ktot());
    chk("fail_total", fail_total_o, exp_ftot());
  endtask

  task automatic step(input bit st, input bit rv, input int op, input int k, input int d,
                      input bit ev, input int ek, input int ed, input bit ret, input bit ri);
    bit exp_ready, accept, had_pend;
    int n;
    @(negedge clk);
    stall_i = st; req_valid_i = rv; req_op_i = op[1:0]; req_key_i = k[KW-1:0];
    req_data_i = d[DW-1:0]; evict_valid_i = ev; evict_key_i = ek[KW-1:0];
    evict_data_i = ed[DW-1:0]; op_retire_i = ret; op_retire_is_insert_i = ri;
    #1;
    had_pend  = (m_pend_key.size() > 0);
    exp_ready = !st && !had_pend && !ev && !(op == 1 && m_chain);
    chk("req_ready", req_ready_o, exp_ready);
    chk("pipe_clk_en", pipe_clk_en_o, !st);
    accept = rv && exp_ready;
    e_pv = 0; e_op = 0; e_key = 0; e_data = 0; e_done = 0; e_fail = 0; e_fk = 0; e_fd = 0;
    if (had_pend && !st) begin
      e_pv = 1; e_op = 1;
      e_key = m_pend_key.pop_front();
      e_data = m_pend_data.pop_front();
    end else if (accept && op != 3) begin
      e_pv = 1; e_op = op; e_key = k; e_data = d;
    end
    if (accept && op == 3) m_err = 1;
    if (!m_chain) begin
      if (ev) m_err = 1;
      if (accept && op == 1) m_chain = 1;
    end else if (!had_pend) begin
      if (ev) begin
        if (m_kicks == MK) begin
          e_fail = 1; e_fk = ek; e_fd = ed; m_kicks = 0; m_chain = 0; m_ftot++;
        end else begin
          m_kicks++; m_ktot++;
          m_pend_key.push_back(ek);
          m_pend_data.push_back(ed);
        end
      end else if (ret && ri) begin
        e_done = 1; m_kicks = 0; m_chain = 0;
      end
    end
    n = m_infl + int'(e_pv) - int'(ret);
    if (n < 0) begin
      n = 0; m_err = 1;
    end
    m_infl = n;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && m_infl > 0; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("drained", idle_o, (!m_chain && m_pend_key.size() == 0 && m_infl == 0));
  endtask

  bit r_st, r_rv, r_ev, r_ret, r_ri;
  int r_op, r_k, r_d, r_ek, r_ed;

  initial begin
    mreset();
    // Reset state
    repeat (2) @(negedge clk);
    check_regs();
    chk("rst_ready_stall0", req_ready_o, 1'b1);
    reset = 1'b1;

    // Single insert, no eviction
    step(0, 1, 1, 1, 5, 0, 0, 0, 0, 0);
    chk("ins1_key", pipe_key_o, 1);
    chk("ins1_data", pipe_data_o, 5);
    repeat (3) nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("ins1_done", ins_done_o, 1'b1);
    nop();
    chk("ins1_idle", idle_o, 1'b1);

    // Insert with two evictions
    step(0, 1, 1, 2, 3, 0, 0, 0, 0, 0);
    repeat (2) nop();
    step(0, 0, 0, 0, 0, 1, 3, 7, 1, 1);
    nop();
    chk("reinj1_key", pipe_key_o, 3);
    nop();
    step(0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    nop();
    chk("reinj2_key", pipe_key_o, 0);
    nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("two_kick_done", ins_done_o, 1'b1);

    // Kick limit: ninth eviction is dropped
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 0, 1, (i == 8) ? 1 : i % 4, (i == 8) ? 9 : i, 1, 1);
      if (i < 8) nop();
    end
    chk("limit_fail", ins_fail_o, 1'b1);
    chk("limit_fkey", fail_key_o, 1);
    chk("limit_fdata", fail_data_o, 9);
    nop();
    chk("limit_idle", idle_o, 1'b1);

    // Eviction and lookup in the same cycle
    step(0, 1, 1, 3, 2, 0, 0, 0, 0, 0);
    nop();
    step(0, 1, 0, 2, 4, 1, 1, 6, 1, 1);
    step(0, 1, 0, 2, 4, 0, 0, 0, 0, 0);
    chk("evfirst_op", pipe_op_o, 1);
    step(0, 1, 0, 2, 4, 0, 0, 0, 0, 0);
    chk("lookup_after_key", pipe_key_o, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drain();

    // Lookups during a chain, second insert held off, stall window
    step(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 8, 0, 0, 0, 0, 0);
    step(0, 1, 1, 2, 2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 2, 3, 1, 1);
    step(1, 1, 1, 2, 2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_pv", pipe_valid_o, 1'b0);
    nop();
    chk("post_stall_key", pipe_key_o, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 1, 3, 3, 0, 0, 0, 0, 0);
    nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drain();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      r_st  = ($urandom % 5) == 0;
      r_rv  = $urandom % 2;
      r_op  = $urandom_range(0, 2);
      r_k   = $urandom % 4;
      r_d   = $urandom % 16;
      r_ev  = m_chain && m_pend_key.size() == 0 && ($urandom % 3) == 0;
      r_ek  = $urandom % 4;
      r_ed  = $urandom % 16;
      r_ret = m_infl > 0 && (m_infl >= 3 || ($urandom % 2) == 1);
      r_ri  = $urandom % 2;
      step(r_st, r_rv, r_op, r_k, r_d, r_ev, r_ek, r_ed, r_ret, r_ri);
    end
    for (int i = 0; i < 40 && m_chain; i++) begin
      r_ret = m_infl > 0;
      step(0, 0, 0, 0, 0, 0, 0, 0, r_ret, r_ret);
    end
    drain();

    // Protocol errors: reserved op, eviction while idle, retire underflow
    step(0, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    chk("rsvd_err", err_o, 1'b1);
    chk("rsvd_noissue", pipe_valid_o, 1'b0);
    step(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop();

    // Asynchronous reset while an eviction is waiting behind a stall
    step(0, 1, 1, 1, 2, 0, 0, 0, 0, 0);
    nop();
    step(1, 0, 0, 0, 0, 1, 3, 5, 1, 1);
    @(negedge clk);
    stall_i = 0; req_valid_i = 0; evict_valid_i = 0; op_retire_i = 0; op_retire_is_insert_i = 0;
    #2 reset = 1'b0;
    #1;
    mreset();
    check_regs();
    @(negedge clk);
    reset = 1'b1;
    nop();
    chk("post_rst_err", err_o, 1'b0);
    chk("post_rst_idle", idle_o, 1'b1);
    nop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
